gcn_aggregate_argmax: RTL and testbench
=======================================

Name: gcn_aggregate_argmax

Overview:
- Downstream stage of the GCN feature-by-weight transformation.
- Consumes the FEATURE_ROWS x WEIGHT_COLS product matrix (FM*WM) and walks the COO edge list one edge per cycle, reading it through coo_address/coo_in.
- Accumulates neighbour rows into per-node aggregates, including the self term.
- Emits, per node, the column index of the largest aggregate on max_addi_answer. Asserts done when finished.

Parameters:
- FEATURE_ROWS, 6, number of graph nodes / product rows
- WEIGHT_COLS, 3, product columns (classes)
- DOT_PROD_WIDTH, 16, width of product elements and of aggregate accumulators
- COO_NUM_OF_COLS, 6, number of edges in the COO list
- COO_BW, $clog2(COO_NUM_OF_COLS), width of one COO node index and of coo_address
- MAX_ADDRESS_WIDTH, 2, width of one argmax result

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  level; begin when sampled high in IDLE
- fm_wm_in  in  [DOT_PROD_WIDTH-1:0] x [0:FEATURE_ROWS-1][0:WEIGHT_COLS-1]  product matrix; upstream holds it stable from start until done
- coo_in  in  2*COO_BW  {source node, destination node} of the edge at coo_address; combinational return from the bench/memory
- coo_address  out  COO_BW  registered edge index being read
- done  out  1  registered; computation complete
- max_addi_answer  out  [MAX_ADDRESS_WIDTH-1:0] x [0:FEATURE_ROWS-1]  registered argmax column per node

Behaviour:
- Reset (async, any state): state=IDLE, all accumulators=0, coo_address=0, done=0, every max_addi_answer entry=0.
- FSM states: IDLE, INIT, EDGE, ARGMAX, DONE.
- IDLE: start=1 -> INIT. Otherwise stay in IDLE.
- INIT (1 cycle):
  - agg[i][j] <= fm_wm_in[i][j], which is the self-loop term.
  - coo_address <= 0, then -> EDGE.
- EDGE (COO_NUM_OF_COLS cycles):
  - Each cycle take src=coo_in[2*COO_BW-1:COO_BW] and dst=coo_in[COO_BW-1:0] for the current coo_address.
  - For all j: agg[src][j] += fm_wm_in[dst][j] and agg[dst][j] += fm_wm_in[src][j].
  - Additions read fm_wm_in, not agg, so the two writes in one cycle never conflict.
  - src==dst: add fm_wm_in[src][j] to agg[src][j] once, not twice.
  - src or dst >= FEATURE_ROWS: skip the whole edge; no accumulator changes.
  - coo_address increments. After index COO_NUM_OF_COLS-1: coo_address <= 0 (no wrap past the last edge) and -> ARGMAX.
- ARGMAX (FEATURE_ROWS cycles, node counter n=0..FEATURE_ROWS-1):
  - max_addi_answer[n] <= index of the largest agg[n][j], compared unsigned.
  - Ties go to the lowest j.
  - After n=FEATURE_ROWS-1 -> DONE.
- DONE:
  - done=1, results held.
  - start=0 -> IDLE; done falls on that edge.
  - While start stays 1 the block remains in DONE; no auto-restart.
- Latency: done rises on the (1+COO_NUM_OF_COLS+FEATURE_ROWS)-th rising edge after the edge that sampled start in IDLE. This is 13 with defaults.
- start is ignored outside IDLE/DONE; deasserting it mid-run does not abort.
- Arithmetic: unsigned. Accumulators are DOT_PROD_WIDTH wide and wrap modulo 2^DOT_PROD_WIDTH.
- max_addi_answer entries keep their prior value until rewritten in ARGMAX. A new run overwrites every entry.
- Reset mid-run aborts immediately to the reset values; a fresh start is required afterwards.

Optional Feature:
- Macro AGG_SATURATE_EN.
- Defined: each accumulator addition saturates at 2^DOT_PROD_WIDTH-1.
- Undefined: additions wrap modulo 2^DOT_PROD_WIDTH.
- Argmax and tie rules are identical in both builds.

Test Plan:
- Nominal: 6-node graph, edges (0,1),(1,2),(2,3),(3,4),(4,5),(5,0). fm_wm row i = {i,0,6-i}.
  - Expected aggregates: node0 {6,0,12}, node3 {9,0,9}.
  - Required: max_addi_answer = {2,2,2,0,0,0}; node3 resolves by tie to 0.
  - done rises exactly 13 clocks after start is sampled; coo_address steps 0..5 during EDGE.
- Self loop / invalid edge: edge list contains (2,2) and (7,1); all else zero.
  - agg[2] = 2*fm_wm[2]; node 1 and node 7 are untouched.
  - Argmax matches the golden model.
- Overflow: fm_wm[0]=fm_wm[1]={16'hFFF0,1,0}, edge (0,1) only.
  - Without AGG_SATURATE_EN: agg[0][0]=16'hFFE0, answer[0]=0.
  - With AGG_SATURATE_EN: agg[0][0]=16'hFFFF, answer[0]=0.
  - Both builds run.
- Reset mid-run: assert reset during EDGE cycle 3.
  - Outputs return to reset values asynchronously; done stays 0.
  - A restart produces correct results.
- Handshake: hold start high through DONE for 5 cycles.
  - done stays 1 and no second run starts.
  - Drop start -> IDLE next edge, done=0.
  - A re-raised start begins a new run and rewrites max_addi_answer.

Source files
------------

// File: rtl/gcn_aggregate_argmax.sv
`default_nettype none
// ============================================================================
//  Module      : gcn_aggregate_argmax
//  Description : GCN aggregation + argmax stage. Walks the COO edge list one
//                edge per cycle, accumulates neighbour rows of the FM*WM
//                product matrix (plus the self term) into per-node
//                aggregates, then emits the argmax column per node.
//  Ports       : clk             - clock, rising edge
//                reset           - asynchronous, active-high reset
//                start           - level start request, sampled in IDLE
//                fm_wm_in        - product matrix, held stable during a run
//                coo_in          - {src, dst} of the edge at coo_address
//                coo_address     - registered edge index being read
//                done            - registered completion flag
//                max_addi_answer - registered argmax column per node
//  Options     : AGG_SATURATE_EN - when defined, accumulator additions
//                saturate at all-ones instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module gcn_aggregate_argmax #(
    parameter int FEATURE_ROWS      = 6,
    parameter int WEIGHT_COLS       = 3,
    parameter int DOT_PROD_WIDTH    = 16,
    parameter int COO_NUM_OF_COLS   = 6,
    parameter int COO_BW            = $clog2(COO_NUM_OF_COLS),
    parameter int MAX_ADDRESS_WIDTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [DOT_PROD_WIDTH-1:0]    fm_wm_in [0:FEATURE_ROWS-1][0:WEIGHT_COLS-1],
    input  logic [2*COO_BW-1:0]          coo_in,
    output logic [COO_BW-1:0]            coo_address,
    output logic                         done,
    output logic [MAX_ADDRESS_WIDTH-1:0] max_addi_answer [0:FEATURE_ROWS-1]
);

    localparam int c_NODE_BW = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_EDGE   = 3'd2,
        S_ARGMAX = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                         r_state_q, w_state_d;
    logic [DOT_PROD_WIDTH-1:0]      r_agg_q [0:FEATURE_ROWS-1][0:WEIGHT_COLS-1];
    logic [DOT_PROD_WIDTH-1:0]      w_agg_d [0:FEATURE_ROWS-1][0:WEIGHT_COLS-1];
    logic [COO_BW-1:0]              r_coo_address_q, w_coo_address_d;
    logic [c_NODE_BW-1:0]           r_node_q, w_node_d;
    logic                           r_done_q, w_done_d;
    logic [MAX_ADDRESS_WIDTH-1:0]   r_ans_q [0:FEATURE_ROWS-1];
    logic [MAX_ADDRESS_WIDTH-1:0]   w_ans_d [0:FEATURE_ROWS-1];

    logic [COO_BW-1:0]              w_src;
    logic [COO_BW-1:0]              w_dst;
    logic                           w_edge_valid;
    logic [MAX_ADDRESS_WIDTH-1:0]   w_best_idx;
    logic [DOT_PROD_WIDTH-1:0]      w_best_val;

    // Accumulator adder: wrapping or saturating depending on build option.
`ifdef AGG_SATURATE_EN
    function automatic logic [DOT_PROD_WIDTH-1:0] f_acc(
        input logic [DOT_PROD_WIDTH-1:0] a,
        input logic [DOT_PROD_WIDTH-1:0] b
    );
        logic [DOT_PROD_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DOT_PROD_WIDTH] ? {DOT_PROD_WIDTH{1'b1}} : sum[DOT_PROD_WIDTH-1:0];
    endfunction
`else
    function automatic logic [DOT_PROD_WIDTH-1:0] f_acc(
        input logic [DOT_PROD_WIDTH-1:0] a,
        input logic [DOT_PROD_WIDTH-1:0] b
    );
        return a + b;
    endfunction
`endif

    assign w_src        = coo_in[2*COO_BW-1:COO_BW];
    assign w_dst        = coo_in[COO_BW-1:0];
    // Edges naming a node outside the graph are dropped entirely.
    assign w_edge_valid = (32'(w_src) < FEATURE_ROWS) && (32'(w_dst) < FEATURE_ROWS);

    // Argmax over the current node's aggregate row; strict '>' keeps the
    // lowest column on ties.
    always_comb begin
        w_best_idx = '0;
        w_best_val = r_agg_q[r_node_q][0];
        for (int j = 1; j < WEIGHT_COLS; j++) begin
            if (r_agg_q[r_node_q][j] > w_best_val) begin
                w_best_val = r_agg_q[r_node_q][j];
                w_best_idx = MAX_ADDRESS_WIDTH'(j);
            end
        end
    end

    always_comb begin
        w_state_d       = r_state_q;
        w_agg_d         = r_agg_q;
        w_coo_address_d = r_coo_address_q;
        w_node_d        = r_node_q;
        w_ans_d         = r_ans_q;
        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_state_d = S_INIT;
                end
            end
            S_INIT: begin
                // Self-loop term seeds every aggregate.
                w_agg_d         = fm_wm_in;
                w_coo_address_d = '0;
                w_state_d       = S_EDGE;
            end
            S_EDGE: begin
                // Sums draw on fm_wm_in rather than agg, so updating both
                // endpoints in the same cycle is order independent.
                if (w_edge_valid) begin
                    for (int j = 0; j < WEIGHT_COLS; j++) begin
                        if (w_src == w_dst) begin
                            w_agg_d[w_src][j] = f_acc(r_agg_q[w_src][j], fm_wm_in[w_src][j]);
                        end else begin
                            w_agg_d[w_src][j] = f_acc(r_agg_q[w_src][j], fm_wm_in[w_dst][j]);
                            w_agg_d[w_dst][j] = f_acc(r_agg_q[w_dst][j], fm_wm_in[w_src][j]);
                        end
                    end
                end
                if (32'(r_coo_address_q) == COO_NUM_OF_COLS - 1) begin
                    w_coo_address_d = '0;
                    w_node_d        = '0;
                    w_state_d       = S_ARGMAX;
                end else begin
                    w_coo_address_d = r_coo_address_q + COO_BW'(1);
                end
            end
            S_ARGMAX: begin
                w_ans_d[r_node_q] = w_best_idx;
                if (32'(r_node_q) == FEATURE_ROWS - 1) begin
                    w_node_d  = '0;
                    w_state_d = S_DONE;
                end else begin
                    w_node_d = r_node_q + c_NODE_BW'(1);
                end
            end
            S_DONE: begin
                // Results held until start is released; no auto-restart.
                if (!start) begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
        w_done_d = (w_state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q       <= S_IDLE;
            r_coo_address_q <= '0;
            r_node_q        <= '0;
            r_done_q        <= 1'b0;
            for (int i = 0; i < FEATURE_ROWS; i++) begin
                r_ans_q[i] <= '0;
                for (int j = 0; j < WEIGHT_COLS; j++) begin
                    r_agg_q[i][j] <= '0;
                end
            end
        end else begin
            r_state_q       <= w_state_d;
            r_coo_address_q <= w_coo_address_d;
            r_node_q        <= w_node_d;
            r_done_q        <= w_done_d;
            r_ans_q         <= w_ans_d;
            r_agg_q         <= w_agg_d;
        end
    end

    assign coo_address     = r_coo_address_q;
    assign done            = r_done_q;
    assign max_addi_answer = r_ans_q;

endmodule
`default_nettype wire

// File: tb/tb_gcn_aggregate_argmax.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gcn_aggregate_argmax
//  Description : Scoreboard bench for gcn_aggregate_argmax. Stimulus pushes
//                the expected argmax vector (from hand-derived constants or a
//                plain-arithmetic graph model) and a monitor checks it when
//                done rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gcn_aggregate_argmax;

    localparam int ROWS  = 6;
    localparam int COLS  = 3;
    localparam int W     = 16;
    localparam int EDGES = 6;
    localparam int CBW   = 3;
    localparam int AW    = 2;
    localparam int LAT   = 13;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [W-1:0]   fm_wm [0:ROWS-1][0:COLS-1];
    logic [2*CBW-1:0] coo_mem [0:EDGES-1];
    logic [2*CBW-1:0] coo_in;
    logic [CBW-1:0] coo_address;
    logic           done;
    logic [AW-1:0]  max_addi_answer [0:ROWS-1];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [2*ROWS-1:0] ans;
        logic [31:0]       start_cyc;
    } exp_t;

    exp_t sb_q[$];

    gcn_aggregate_argmax #(
        .FEATURE_ROWS      (ROWS),
        .WEIGHT_COLS       (COLS),
        .DOT_PROD_WIDTH    (W),
        .COO_NUM_OF_COLS   (EDGES),
        .COO_BW            (CBW),
        .MAX_ADDRESS_WIDTH (AW)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .fm_wm_in        (fm_wm),
        .coo_in          (coo_in),
        .coo_address     (coo_address),
        .done            (done),
        .max_addi_answer (max_addi_answer)
    );

    assign coo_in = coo_mem[coo_address];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: plain graph arithmetic on the edge list.
    function automatic longint acc(input longint a, input longint b);
        longint v;
        v = a + b;
`ifdef AGG_SATURATE_EN
        return (v > (64'd1 << W) - 1) ? (64'd1 << W) - 1 : v;
`else
        return v % (64'd1 << W);
`endif
    endfunction

    function automatic logic [2*ROWS-1:0] model();
        longint agg [ROWS][COLS];
        logic [2*ROWS-1:0] r;
        int s, d, best;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                agg[i][j] = fm_wm[i][j];
        for (int e = 0; e < EDGES; e++) begin
            s = int'(coo_mem[e][2*CBW-1:CBW]);
            d = int'(coo_mem[e][CBW-1:0]);
            if (s < ROWS && d < ROWS) begin
                for (int j = 0; j < COLS; j++) begin
                    if (s == d) begin
                        agg[s][j] = acc(agg[s][j], fm_wm[s][j]);
                    end else begin
                        agg[s][j] = acc(agg[s][j], fm_wm[d][j]);
                        agg[d][j] = acc(agg[d][j], fm_wm[s][j]);
                    end
                end
            end
        end
        r = '0;
        for (int n = 0; n < ROWS; n++) begin
            best = 0;
            for (int j = 1; j < COLS; j++)
                if (agg[n][j] > agg[n][best]) best = j;
            r[2*n +: 2] = AW'(best);
        end
        return r;
    endfunction

    // Monitor: on every rising done, pop and compare.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1 && done_prev !== 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done got=1 expected=no pending run (t=%0t)", $time);
            end else begin
                e = sb_q.pop_front();
                check("latency", cyc - e.start_cyc, LAT);
                for (int n = 0; n < ROWS; n++)
                    check($sformatf("ans[%0d]", n), 32'(max_addi_answer[n]), 32'(e.ans[2*n +: 2]));
            end
        end
        done_prev <= done;
    end

    task automatic wait_done();
        for (int i = 0; i < 40 && done !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        if (done !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL done_timeout got=%b expected=1 (t=%0t)", done, $time);
        end
    endtask

    // Called at posedge+1 with the DUT idle.
    task automatic run_case(input logic [2*ROWS-1:0] exp_ans, input bit hold_start, input bit check_coo);
        exp_t item;
        item.ans       = exp_ans;
        item.start_cyc = 32'(cyc + 1);
        sb_q.push_back(item);
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        if (check_coo) begin
            for (int k = 0; k < EDGES; k++) begin
                @(posedge clk); #1;
                check("coo_address_step", 32'(coo_address), 32'(k));
            end
        end
        wait_done();
        if (!hold_start) begin
            @(posedge clk); #1;
            check("done_fall", 32'(done), 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_coo_address"}, 32'(coo_address), 0);
        for (int n = 0; n < ROWS; n++)
            check($sformatf("%s_ans[%0d]", tag, n), 32'(max_addi_answer[n]), 0);
    endtask

    task automatic clear_data();
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                fm_wm[i][j] = '0;
        for (int e = 0; e < EDGES; e++)
            coo_mem[e] = {3'd7, 3'd7};
    endtask

    task automatic random_data(input bit big);
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                fm_wm[i][j] = big ? W'($urandom) : W'($urandom_range(0, 20));
        for (int e = 0; e < EDGES; e++)
            coo_mem[e] = {CBW'($urandom_range(0, 7)), CBW'($urandom_range(0, 7))};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        clear_data();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Nominal ring graph, rows {i,0,6-i}.
        for (int i = 0; i < ROWS; i++) begin
            fm_wm[i][0] = W'(i);
            fm_wm[i][1] = '0;
            fm_wm[i][2] = W'(6 - i);
            coo_mem[i]  = {CBW'(i), CBW'((i + 1) % ROWS)};
        end
        run_case({2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2}, 1'b0, 1'b1);

        // Abort during EDGE cycle 3.
        random_data(1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        repeat (4) @(posedge clk);
        #1;
        check("midrun_coo_address", 32'(coo_address), 3);
        #1;
        reset = 1'b1;
        start = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("idle_after_reset_done", 32'(done), 0);
        end
        run_case(model(), 1'b0, 1'b0);

        // Self loop and out-of-range edges.
        random_data(1'b0);
        coo_mem[0] = {3'd2, 3'd2};
        coo_mem[1] = {3'd7, 3'd1};
        coo_mem[2] = {3'd6, 3'd3};
        coo_mem[3] = {3'd0, 3'd7};
        coo_mem[4] = {3'd7, 3'd7};
        coo_mem[5] = {3'd3, 3'd6};
        run_case(model(), 1'b0, 1'b0);

        // Overflow: identical rows, argmax column 0 in either build.
        clear_data();
        fm_wm[0][0] = 16'hFFF0; fm_wm[0][1] = 16'd1;
        fm_wm[1][0] = 16'hFFF0; fm_wm[1][1] = 16'd1;
        coo_mem[0] = {3'd0, 3'd1};
        run_case('0, 1'b0, 1'b0);

        // Overflow where wrap and saturate disagree on the argmax.
        clear_data();
        fm_wm[0][0] = 16'hFFF0; fm_wm[0][1] = 16'hFFF5;
        fm_wm[1][0] = 16'd32;   fm_wm[1][1] = 16'd1;
        coo_mem[0] = {3'd0, 3'd1};
`ifdef AGG_SATURATE_EN
        run_case('0, 1'b0, 1'b0);
`else
        run_case({8'd0, 2'd1, 2'd1}, 1'b0, 1'b0);
`endif

        // Random graphs, alternating small and full-range values.
        for (int r = 0; r < 6; r++) begin
            random_data(r[0]);
            run_case(model(), 1'b0, 1'b0);
        end

        // Handshake: start held through DONE.
        clear_data();
        for (int i = 0; i < ROWS; i++) fm_wm[i][2] = W'(i + 1);
        run_case(12'hAAA, 1'b1, 1'b0);
        repeat (5) begin
            @(posedge clk); #1;
            check("done_held", 32'(done), 1);
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("done_drop", 32'(done), 0);
        @(posedge clk); #1;
        check("idle_done", 32'(done), 0);
        clear_data();
        for (int i = 0; i < ROWS; i++) fm_wm[i][0] = W'(i + 1);
        run_case('0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
